// File: rtl/idma_ibuf_pingpong_sched.sv
// Ping-pong scheduler for the instruction buffer. It splits one instruction-stream job into
// chunks. It fills the two ibuffer banks from DDR one after the other. Each filled bank is
// handed to the ibuffer-to-NoC reader, so the fill of one bank overlaps the drain of the other.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_*                  job start pulse and job configuration
//   busy / done / err      job status; done is a one-cycle pulse, err is sticky until a valid start
//   fill_*                 DMA fill request (valid/ready), chunk address/length, completion pulse
//   drain_*                ibuffer read start pulse with bank base/length, completion pulse
module idma_ibuf_pingpong_sched #(
    parameter int unsigned MEM_AW  = 15,
    parameter int unsigned WORD_AW = MEM_AW + 2,
    parameter int unsigned NUM_W   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [31:0]        cfg_ddr_addr,
    input  logic [31:0]        cfg_total_words,
    input  logic [NUM_W-1:0]   cfg_chunk_words,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               fill_req,
    input  logic               fill_ready,
    output logic [31:0]        fill_addr,
    output logic [31:0]        fill_num,
    output logic [WORD_AW-1:0] fill_ibuf_word_addr,
    input  logic               fill_done,
    output logic               drain_start,
    output logic [WORD_AW-1:0] drain_word_addr,
    output logic [NUM_W-1:0]   drain_word_num,
    input  logic               drain_done
);

    localparam int unsigned BANK_WORDS = 2 ** (MEM_AW + 1);
    localparam logic [WORD_AW-1:0] BANK1_BASE = WORD_AW'(BANK_WORDS);

    typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull, BankDraining} bank_st_e;
    typedef enum logic [1:0] {FIdle, FReq, FWait} fill_st_e;
    typedef enum logic {DIdle, DWait} drain_st_e;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    fill_st_e           f_st_q, f_st_d;
    drain_st_e          d_st_q, d_st_d;
    bank_st_e           bank_st_q [2];
    bank_st_e           bank_st_d [2];
    logic [NUM_W-1:0]   bank_len_q [2];
    logic [NUM_W-1:0]   bank_len_d [2];
    logic               fill_ptr_q, fill_ptr_d;
    logic               drain_ptr_q, drain_ptr_d;
    logic [31:0]        fill_rem_q, fill_rem_d;
    logic [31:0]        ddr_ptr_q, ddr_ptr_d;
    logic [NUM_W-1:0]   chunk_q, chunk_d;
    logic               drain_start_q, drain_start_d;
    logic [WORD_AW-1:0] drain_addr_q, drain_addr_d;
    logic [NUM_W-1:0]   drain_num_q, drain_num_d;

    logic [31:0] chunk_ext;
    logic [31:0] cur_num;
    logic        cfg_bad;

    assign chunk_ext = 32'(chunk_q);
    assign cur_num   = (fill_rem_q < chunk_ext) ? fill_rem_q : chunk_ext;
    assign cfg_bad   = (cfg_chunk_words == '0) || (32'(cfg_chunk_words) > BANK_WORDS);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            f_st_q        <= FIdle;
            d_st_q        <= DIdle;
            bank_st_q[0]  <= BankEmpty;
            bank_st_q[1]  <= BankEmpty;
            bank_len_q[0] <= '0;
            bank_len_q[1] <= '0;
            fill_ptr_q    <= 1'b0;
            drain_ptr_q   <= 1'b0;
            fill_rem_q    <= '0;
            ddr_ptr_q     <= '0;
            chunk_q       <= '0;
            drain_start_q <= 1'b0;
            drain_addr_q  <= '0;
            drain_num_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            f_st_q        <= f_st_d;
            d_st_q        <= d_st_d;
            bank_st_q[0]  <= bank_st_d[0];
            bank_st_q[1]  <= bank_st_d[1];
            bank_len_q[0] <= bank_len_d[0];
            bank_len_q[1] <= bank_len_d[1];
            fill_ptr_q    <= fill_ptr_d;
            drain_ptr_q   <= drain_ptr_d;
            fill_rem_q    <= fill_rem_d;
            ddr_ptr_q     <= ddr_ptr_d;
            chunk_q       <= chunk_d;
            drain_start_q <= drain_start_d;
            drain_addr_q  <= drain_addr_d;
            drain_num_q   <= drain_num_d;
        end
    end

    always_comb begin
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
        f_st_d        = f_st_q;
        d_st_d        = d_st_q;
        bank_st_d[0]  = bank_st_q[0];
        bank_st_d[1]  = bank_st_q[1];
        bank_len_d[0] = bank_len_q[0];
        bank_len_d[1] = bank_len_q[1];
        fill_ptr_d    = fill_ptr_q;
        drain_ptr_d   = drain_ptr_q;
        fill_rem_d    = fill_rem_q;
        ddr_ptr_d     = ddr_ptr_q;
        chunk_d       = chunk_q;
        drain_start_d = 1'b0;
        drain_addr_d  = '0;
        drain_num_d   = '0;

        if (cfg_start && !busy_q) begin
            fill_ptr_d  = 1'b0;
            drain_ptr_d = 1'b0;
            if (cfg_bad) begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end else begin
                err_d      = 1'b0;
                chunk_d    = cfg_chunk_words;
                fill_rem_d = cfg_total_words;
                ddr_ptr_d  = cfg_ddr_addr;
                if (cfg_total_words == '0) begin
                    done_d = 1'b1;
                end else begin
                    // Claim bank 0 right away so the first request shows up next cycle.
                    busy_d       = 1'b1;
                    f_st_d       = FReq;
                    bank_st_d[0] = BankFilling;
                end
            end
        end else if (busy_q) begin
            // Completions first, so a bank freed this cycle is visible to the fill launch below.
            if (f_st_q == FWait && fill_done) begin
                bank_st_d[fill_ptr_q] = BankFull;
                fill_ptr_d            = ~fill_ptr_q;
                f_st_d                = FIdle;
            end
            if (d_st_q == DWait && drain_done) begin
                bank_st_d[drain_ptr_q] = BankEmpty;
                drain_ptr_d            = ~drain_ptr_q;
                d_st_d                 = DIdle;
            end

            if (d_st_q == DIdle && bank_st_q[drain_ptr_q] == BankFull) begin
                drain_start_d          = 1'b1;
                drain_addr_d           = drain_ptr_q ? BANK1_BASE : '0;
                drain_num_d            = bank_len_q[drain_ptr_q];
                bank_st_d[drain_ptr_q] = BankDraining;
                d_st_d                 = DWait;
            end

            case (f_st_q)
                FIdle: begin
                    if (fill_rem_q != '0 && bank_st_d[fill_ptr_q] == BankEmpty) begin
                        f_st_d                = FReq;
                        bank_st_d[fill_ptr_q] = BankFilling;
                    end
                end
                FReq: begin
                    if (fill_ready) begin
                        f_st_d                 = FWait;
                        bank_len_d[fill_ptr_q] = cur_num[NUM_W-1:0];
                        ddr_ptr_d              = ddr_ptr_q + {cur_num[29:0], 2'b00};
                        fill_rem_d             = fill_rem_q - cur_num;
                    end
                end
                default: ;
            endcase

            if (fill_rem_q == '0 && bank_st_q[0] == BankEmpty && bank_st_q[1] == BankEmpty &&
                f_st_q == FIdle && d_st_q == DIdle) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Request fields are zero whenever no request is outstanding.
    always_comb begin
        busy                = busy_q;
        done                = done_q;
        err                 = err_q;
        fill_req            = (f_st_q == FReq);
        fill_addr           = fill_req ? ddr_ptr_q : '0;
        fill_num            = fill_req ? cur_num : '0;
        fill_ibuf_word_addr = (fill_req && fill_ptr_q) ? BANK1_BASE : '0;
        drain_start         = drain_start_q;
        drain_word_addr     = drain_addr_q;
        drain_word_num      = drain_num_q;
    end

endmodule

// File: tb/tb_idma_ibuf_pingpong_sched.sv
`timescale 1ns/1ps
module tb_idma_ibuf_pingpong_sched;

    localparam int unsigned MEM_AW     = 4;
    localparam int unsigned WORD_AW    = MEM_AW + 2;
    localparam int unsigned NUM_W      = 13;
    localparam int unsigned BANK_WORDS = 32;
    localparam logic [WORD_AW-1:0] B1  = WORD_AW'(BANK_WORDS);

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic [31:0]        cfg_ddr_addr;
    logic [31:0]        cfg_total_words;
    logic [NUM_W-1:0]   cfg_chunk_words;
    logic               busy, done, err;
    logic               fill_req, fill_ready, fill_done;
    logic [31:0]        fill_addr, fill_num;
    logic [WORD_AW-1:0] fill_ibuf_word_addr;
    logic               drain_start, drain_done;
    logic [WORD_AW-1:0] drain_word_addr;
    logic [NUM_W-1:0]   drain_word_num;

    always #5 clk = ~clk;

    idma_ibuf_pingpong_sched #(
        .MEM_AW (MEM_AW),
        .WORD_AW(WORD_AW),
        .NUM_W  (NUM_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_start          (cfg_start),
        .cfg_ddr_addr       (cfg_ddr_addr),
        .cfg_total_words    (cfg_total_words),
        .cfg_chunk_words    (cfg_chunk_words),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .fill_req           (fill_req),
        .fill_ready         (fill_ready),
        .fill_addr          (fill_addr),
        .fill_num           (fill_num),
        .fill_ibuf_word_addr(fill_ibuf_word_addr),
        .fill_done          (fill_done),
        .drain_start        (drain_start),
        .drain_word_addr    (drain_word_addr),
        .drain_word_num     (drain_word_num),
        .drain_done         (drain_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected transaction lists built from the job description.
    logic [31:0]        ef_addr[$];
    logic [31:0]        ef_num[$];
    logic [WORD_AW-1:0] ef_w[$];
    logic [WORD_AW-1:0] ed_w[$];
    logic [31:0]        ed_num[$];

    task automatic start_pulse(input logic [31:0] a, input logic [31:0] t, input logic [NUM_W-1:0] c);
        cfg_ddr_addr = a; cfg_total_words = t; cfg_chunk_words = c; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_fill_req"}, fill_req, 0);
        check({tag, "_drain_start"}, drain_start, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // rnd: random ready/delays; hold>0: first drain_done withheld for hold cycles.
    task automatic run_job(input logic [31:0] addr, input logic [31:0] total,
                           input logic [NUM_W-1:0] chunk, input bit rnd, input int hold);
        logic [31:0] rem, a, n;
        int  k, fd_cnt, dd_cnt, fills_done, drains_done, drains_started, coin_win;
        bit  got_done, exp_freq, coin_ds, coin_fr, coin_fill_more;
        logic [WORD_AW-1:0] coin_fb, coin_db;
        ef_addr.delete(); ef_num.delete(); ef_w.delete(); ed_w.delete(); ed_num.delete();
        rem = total; a = addr; k = 0;
        while (rem != 0) begin
            n = (rem < 32'(chunk)) ? rem : 32'(chunk);
            ef_addr.push_back(a);
            ef_num.push_back(n);
            ef_w.push_back((k % 2 == 1) ? B1 : '0);
            ed_w.push_back((k % 2 == 1) ? B1 : '0);
            ed_num.push_back(n);
            a   = a + (n << 2);
            rem = rem - n;
            k++;
        end
        @(negedge clk);
        start_pulse(addr, total, chunk);
        fd_cnt = -1; dd_cnt = -1; fills_done = 0; drains_done = 0; drains_started = 0;
        got_done = 0; exp_freq = 0; coin_win = -1; coin_ds = 0; coin_fr = 0;
        coin_fill_more = 0; coin_fb = '0; coin_db = '0;
        check("err_after_valid_start", err, 0);
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            // observe
            if (exp_freq) begin
                check("fill_req_after_drain_done", fill_req, 1);
                exp_freq = 0;
            end
            if (hold > 0 && fills_done >= 2 && drains_done == 0)
                check("fill_req_held_while_banks_busy", fill_req, 0);
            if (coin_win > 0) begin
                if (drain_start && drain_word_addr == coin_fb) coin_ds = 1;
                if (fill_req && fill_ibuf_word_addr == coin_db) coin_fr = 1;
                coin_win--;
                if (coin_win == 0) begin
                    check("coincident_drain_start", coin_ds, 1);
                    if (coin_fill_more) check("coincident_fill_req", coin_fr, 1);
                end
            end
            if (drain_start) begin
                if (ed_w.size() == 0) check("drain_extra", 1, 0);
                else begin
                    check("drain_addr", drain_word_addr, ed_w.pop_front());
                    check("drain_num", drain_word_num, ed_num.pop_front());
                end
            end
            if (done) begin
                check("done_busy_low", busy, 0);
                check("done_err_low", err, 0);
                got_done = 1;
            end
            // respond
            cfg_start  = 1'b0;
            fill_done  = 1'b0;
            drain_done = 1'b0;
            if (fd_cnt == 0) begin
                fill_done = 1'b1; fd_cnt = -1; fills_done++;
            end else if (fd_cnt > 0) fd_cnt--;
            if (dd_cnt == 0) begin
                drain_done = 1'b1; dd_cnt = -1; drains_done++;
                if (hold > 0 && drains_done == 1) exp_freq = 1;
            end else if (dd_cnt > 0) dd_cnt--;
            if (fill_done && drain_done) begin
                coin_win = 2; coin_ds = 0; coin_fr = 0;
                coin_fb  = ((fills_done - 1) % 2 == 1) ? B1 : '0;
                coin_db  = ((drains_done - 1) % 2 == 1) ? B1 : '0;
                coin_fill_more = (ef_addr.size() != 0);
            end
            if (drain_start) begin
                dd_cnt = rnd ? int'($urandom_range(0, 4)) : 0;
                if (hold > 0 && drains_started == 0) dd_cnt = hold;
                drains_started++;
            end
            fill_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (fill_req && fill_ready) begin
                if (ef_addr.size() == 0) check("fill_extra", 1, 0);
                else begin
                    check("fill_addr", fill_addr, ef_addr.pop_front());
                    check("fill_num", fill_num, ef_num.pop_front());
                    check("fill_ibuf_word_addr", fill_ibuf_word_addr, ef_w.pop_front());
                end
                fd_cnt = rnd ? int'($urandom_range(0, 4)) : 0;
            end
            // a start while busy must be ignored
            if (rnd && busy && $urandom_range(0, 7) == 0) begin
                cfg_start = 1'b1; cfg_chunk_words = '0;
                cfg_total_words = $urandom; cfg_ddr_addr = $urandom;
            end
            @(negedge clk);
        end
        cfg_start = 1'b0; fill_ready = 1'b0; fill_done = 1'b0; drain_done = 1'b0;
        if (!got_done) check("job_done_timeout", 0, 1);
        check("fills_outstanding", ef_addr.size(), 0);
        check("drains_outstanding", ed_w.size(), 0);
        check("done_single_pulse", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; cfg_start = 1'b0; cfg_ddr_addr = '0; cfg_total_words = '0;
        cfg_chunk_words = '0; fill_ready = 1'b0; fill_done = 1'b0; drain_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fill_req", fill_req, 0);
        check("rst_drain_start", drain_start, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic job with immediate responders (also hits coincident fill_done/drain_done).
        run_job(32'h1000, 100, 32, 0, 0);
        // Drain of bank 0 withheld.
        run_job(32'h1000, 100, 32, 0, 8);

        // Zero-length job.
        start_pulse(32'h2000, 0, 16);
        check("zero_done", done, 1);
        check("zero_err", err, 0);
        check_quiet("zero");
        @(negedge clk);
        check("zero_done_once", done, 0);
        check_quiet("zero_after");

        // Oversized chunk, then chunk of zero.
        start_pulse(32'h3000, 50, 33);
        check("bad_err", err, 1);
        check("bad_done", done, 1);
        check_quiet("bad");
        repeat (3) begin
            @(negedge clk);
            check("bad_done_once", done, 0);
            check("bad_err_sticky", err, 1);
            check_quiet("bad_after");
        end
        run_job(32'h3000, 50, 32, 0, 0);
        start_pulse(32'h3000, 50, 0);
        check("zero_chunk_err", err, 1);
        check("zero_chunk_done", done, 1);
        check_quiet("zero_chunk");
        @(negedge clk);

        // Reset while a drain is outstanding.
        start_pulse(32'h1000, 100, 32);
        fill_ready = 1'b1; fill_done = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (drain_start) seen = 1;
            else @(negedge clk);
        end
        check("rst_mid_reached_drain", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fill_ready = 1'b0; fill_done = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_fill_req", fill_req, 0);
        check("midrst_fill_addr", fill_addr, 0);
        check("midrst_fill_num", fill_num, 0);
        check("midrst_fill_waddr", fill_ibuf_word_addr, 0);
        check("midrst_drain_start", drain_start, 0);
        check("midrst_drain_addr", drain_word_addr, 0);
        check("midrst_drain_num", drain_word_num, 0);
        drain_done = 1'b1;
        @(negedge clk);
        drain_done = 1'b0;
        repeat (3) begin
            check("late_drain_done_done", done, 0);
            check_quiet("late_drain_done");
            @(negedge clk);
        end
        run_job(32'h1000, 100, 32, 0, 0);

        // Address wrap and randomized jobs.
        run_job(32'hFFFF_FFC0, 40, 8, 1, 0);
        for (int j = 0; j < 8; j++)
            run_job($urandom, $urandom_range(1, 200), NUM_W'($urandom_range(1, BANK_WORDS)), 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
